pool_unit: RTL and testbench

//  Streaming 2-D max/avg pooling on systolic-array output vectors, one NUM_LANES-wide row per beat.

---
 rtl/pool_pkg.sv | 30 +++
 rtl/pool_lane_reduce.sv | 63 ++++++
 rtl/pool_unit.sv | 161 ++++++++++++++++
 tb/tb_pool_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling unit.
// Optional build macro: POOL_RELU_EN (clamp pooled outputs at zero).
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pool_state_t;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  localparam logic [1:0] WIN_K1     = 2'b00;
  localparam logic [1:0] WIN_K2     = 2'b01;
  localparam logic [1:0] WIN_K4     = 2'b10;
  localparam logic [1:0] WIN_K1_ALT = 2'b11;

  // Guard bits on top of DWIDTH for the average accumulator (16 elements max).
  localparam int unsigned ACC_GUARD = 4;

  function automatic logic [1:0] win_log2(input logic [1:0] pool_window);
    case (pool_window)
      WIN_K2:  return 2'd1;
      WIN_K4:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pool_lane_reduce.sv
// One pooled output lane: reduces up to 4 horizontal inputs per row and
// folds consecutive rows of a window into an accumulator.
// Optional build macro: POOL_RELU_EN.
module pool_lane_reduce
  import pool_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  beat,
  input  logic                  first_row,
  input  logic                  mode,
  input  logic [1:0]            log2k,
  input  logic [4*DWIDTH-1:0]   elems,
  input  logic [3:0]            mask,
  output logic [DWIDTH-1:0]     result
);

  localparam int AW = DWIDTH + int'(ACC_GUARD);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] row_max;
  logic signed [AW-1:0] row_sum;
  logic signed [AW-1:0] row_red;
  logic signed [AW-1:0] folded;
  logic signed [AW-1:0] ext;
  logic        [2:0]    shamt;

  // Row reduction, fold with the running window value, and finalize.
  // Missing rows of a partial window need no special handling: they would
  // contribute the max identity or zero, so finalizing the fold is enough.
  always_comb begin
    row_max = {{(AW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
    row_sum = '0;
    ext     = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      ext = {{(AW-DWIDTH){elems[p*DWIDTH+DWIDTH-1]}}, elems[p*DWIDTH +: DWIDTH]};
      if (mask[p]) begin
        if (ext > row_max) row_max = ext;
        row_sum = row_sum + ext;
      end
    end
    row_red = (mode == POOL_AVG) ? row_sum : row_max;
    if (first_row)            folded = row_red;
    else if (mode == POOL_AVG) folded = acc + row_red;
    else                      folded = (acc > row_red) ? acc : row_red;
    shamt  = (mode == POOL_AVG) ? {log2k, 1'b0} : 3'd0;
    result = DWIDTH'(folded >>> shamt);
`ifdef POOL_RELU_EN
    if (result[DWIDTH-1]) result = '0;
`endif
  end

  // Window accumulator, cleared whenever no job is active.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   acc <= '0;
    else if (clr)  acc <= '0;
    else if (beat) acc <= folded;
  end

endmodule

// File: rtl/pool_unit.sv
// Streaming KxK max/avg pooling (K = 1, 2, 4; stride K) over row vectors.
// Pooled lanes are packed toward lane 0; upper lanes read zero.
// Optional build macro: POOL_RELU_EN (clamp each pooled element at zero).
module pool_unit
  import pool_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int NUM_LANES  = 16,
  parameter int MASK_WIDTH = 16,
  parameter int ROWCNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable_pool,
  input  logic                          pool_mode,
  input  logic [1:0]                    pool_window,
  input  logic [ROWCNT_W-1:0]           pool_rows,
  input  logic                          in_data_available,
  input  logic [NUM_LANES*DWIDTH-1:0]   inp_data,
  input  logic [MASK_WIDTH-1:0]         validity_mask,
  output logic [NUM_LANES*DWIDTH-1:0]   out_data,
  output logic                          out_data_available,
  output logic                          done_pool
);

  localparam int LW = $clog2(NUM_LANES);

  pool_state_t           state;
  logic                  cfg_mode;
  logic [1:0]            cfg_log2k;
  logic [ROWCNT_W-1:0]   cfg_rows;
  logic [ROWCNT_W-1:0]   row_cnt;
  logic [1:0]            win_cnt;
  logic [1:0]            win_last;
  logic [2:0]            kval;
  logic [LW:0]           active_lanes;
  logic                  accept;
  logic                  last_row;
  logic                  win_done;
  logic                  first_row;
  logic                  lane_clr;

  logic [DWIDTH-1:0]           lane_in [NUM_LANES];
  logic [DWIDTH-1:0]           res     [NUM_LANES];
  logic [NUM_LANES*DWIDTH-1:0] pooled;

  // Beat acceptance and window bookkeeping.
  always_comb begin
    case (cfg_log2k)
      2'd1:    win_last = 2'd1;
      2'd2:    win_last = 2'd3;
      default: win_last = 2'd0;
    endcase
    kval         = 3'd1 << cfg_log2k;
    active_lanes = (LW+1)'(NUM_LANES) >> cfg_log2k;
    accept       = (state == ACCUM) && enable_pool && in_data_available && (row_cnt < cfg_rows);
    last_row     = (row_cnt == cfg_rows - ROWCNT_W'(1));
    win_done     = accept && ((win_cnt == win_last) || last_row);
    first_row    = (win_cnt == 2'd0);
    lane_clr     = (state == IDLE);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_unpack
    assign lane_in[i] = inp_data[i*DWIDTH +: DWIDTH];
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    logic [4*DWIDTH-1:0] elems;
    logic [3:0]          mask;
    logic [LW+1:0]       idx;

    // Gather input lanes j*K .. j*K+K-1; absent positions are masked off.
    always_comb begin
      elems = '0;
      mask  = '0;
      idx   = '0;
      for (int unsigned p = 0; p < 4; p++) begin
        idx = ((LW+2)'(j) << cfg_log2k) + (LW+2)'(p);
        if ((3'(p) < kval) && (idx < (LW+2)'(NUM_LANES))) begin
          elems[p*DWIDTH +: DWIDTH] = lane_in[idx[LW-1:0]];
          mask[p]                   = validity_mask[idx[LW-1:0]];
        end
      end
    end

    pool_lane_reduce #(.DWIDTH(DWIDTH)) u_reduce (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (lane_clr),
      .beat      (accept),
      .first_row (first_row),
      .mode      (cfg_mode),
      .log2k     (cfg_log2k),
      .elems     (elems),
      .mask      (mask),
      .result    (res[j])
    );

    assign pooled[j*DWIDTH +: DWIDTH] = ((LW+1)'(j) < active_lanes) ? res[j] : '0;
  end

  // Job FSM, counters, config latches and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      cfg_mode           <= POOL_MAX;
      cfg_log2k          <= '0;
      cfg_rows           <= '0;
      row_cnt            <= '0;
      win_cnt            <= '0;
      out_data           <= '0;
      out_data_available <= 1'b0;
      done_pool          <= 1'b0;
    end else begin
      out_data_available <= 1'b0;
      case (state)
        IDLE: begin
          row_cnt <= '0;
          win_cnt <= '0;
          if (enable_pool) begin
            cfg_mode  <= pool_mode;
            cfg_log2k <= win_log2(pool_window);
            cfg_rows  <= pool_rows;
            if (pool_rows == '0) begin
              state     <= DONE;
              done_pool <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (!enable_pool) begin
            state   <= IDLE;
            row_cnt <= '0;
            win_cnt <= '0;
          end else if (accept) begin
            row_cnt <= row_cnt + ROWCNT_W'(1);
            win_cnt <= win_done ? 2'd0 : win_cnt + 2'd1;
            if (win_done) begin
              out_data           <= pooled;
              out_data_available <= 1'b1;
            end
            if (last_row) begin
              state     <= DONE;
              done_pool <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!enable_pool) begin
            state     <= IDLE;
            done_pool <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_unit.sv
// Directed, table-driven bench for pool_unit.
module tb_pool_unit;

  localparam int DW = 8;
  localparam int NL = 16;
  localparam int VW = DW * NL;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable_pool;
  logic          pool_mode;
  logic [1:0]    pool_window;
  logic [7:0]    pool_rows;
  logic          in_data_available;
  logic [VW-1:0] inp_data;
  logic [15:0]   validity_mask;
  logic [VW-1:0] out_data;
  logic          out_data_available;
  logic          done_pool;

  int total = 0;
  int bad   = 0;

  pool_unit #(
    .DWIDTH     (DW),
    .NUM_LANES  (NL),
    .MASK_WIDTH (16),
    .ROWCNT_W   (8)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .enable_pool        (enable_pool),
    .pool_mode          (pool_mode),
    .pool_window        (pool_window),
    .pool_rows          (pool_rows),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_pool          (done_pool)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          mode;
    logic [15:0]   mask;
    logic [VW-1:0] r0;
    logic [VW-1:0] r1;
    logic [VW-1:0] exp;
  } vec_t;

  vec_t tv[8];
  int   nv = 0;

  function automatic int relu(input int x);
`ifdef POOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [VW-1:0] mk_row(input int a0, input int a1, input int a2,
                                           input int a3, input int fill);
    logic [VW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      case (i)
        0:       v = a0;
        1:       v = a1;
        2:       v = a2;
        3:       v = a3;
        default: v = fill;
      endcase
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  // K=2 expectation: lanes 0,1 given, lanes 2..7 mid, lanes 8..15 zero.
  function automatic logic [VW-1:0] mk_exp(input int e0, input int e1, input int mid);
    logic [VW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v = relu((i == 0) ? e0 : (i == 1) ? e1 : mid);
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] pat(input int k);
    logic [VW-1:0] r;
    int v;
    for (int i = 0; i < NL; i++) begin
      v = i * 13 + k * 37 - 100;
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] fill_lanes(input int n, input int base, input int step);
    logic [VW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < n; i++) begin
      v = base + i * step;
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  task automatic add_vec(input string name, input logic mode, input logic [15:0] mask,
                         input logic [VW-1:0] r0, input logic [VW-1:0] r1,
                         input logic [VW-1:0] exp);
    tv[nv].name = name;
    tv[nv].mode = mode;
    tv[nv].mask = mask;
    tv[nv].r0   = r0;
    tv[nv].r1   = r1;
    tv[nv].exp  = exp;
    nv++;
  endtask

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [1:0] w, input logic m, input int rows);
    @(negedge clk);
    pool_window = w;
    pool_mode   = m;
    pool_rows   = rows[7:0];
    enable_pool = 1'b1;
    @(negedge clk);
  endtask

  task automatic beat(input logic [VW-1:0] d, input logic [15:0] m);
    inp_data          = d;
    validity_mask     = m;
    in_data_available = 1'b1;
    @(negedge clk);
    in_data_available = 1'b0;
  endtask

  task automatic stop();
    enable_pool = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [VW-1:0] w1_exp;
    logic [VW-1:0] w2_exp;
    logic          seen;

    resetn            = 1'b0;
    enable_pool       = 1'b0;
    pool_mode         = 1'b0;
    pool_window       = 2'b00;
    pool_rows         = '0;
    in_data_available = 1'b0;
    inp_data          = '0;
    validity_mask     = '1;

    add_vec("k2_max_basic", 1'b0, 16'hFFFF, mk_row(1, 5, -3, 2, 9), mk_row(4, 0, 7, -8, 9),
            mk_exp(5, 7, 9));
    add_vec("k2_avg_sum11", 1'b1, 16'hFFFF, mk_row(3, 4, 0, 0, 9), mk_row(5, -1, 0, 0, 9),
            mk_exp(2, 0, 9));
    add_vec("k2_avg_neg8", 1'b1, 16'hFFFF, mk_row(-8, -8, -8, -8, -8), mk_row(-8, -8, -8, -8, -8),
            mk_exp(-8, -8, -8));
    add_vec("k2_avg_floor", 1'b1, 16'hFFFF, mk_row(-1, 0, 0, 0, 0), mk_row(0, 0, 0, 0, 0),
            mk_exp(-1, 0, 0));
    add_vec("k2_max_mask1", 1'b0, 16'h0001, mk_row(-100, 50, 1, 1, 3), mk_row(-100, 50, 1, 1, 3),
            mk_exp(-100, -128, -128));
    add_vec("k2_avg_mask3", 1'b1, 16'h0003, mk_row(10, 20, 30, 40, 5), mk_row(2, 4, 6, 8, 5),
            mk_exp(9, 0, 0));
    add_vec("k2_max_extreme", 1'b0, 16'hFFFF, mk_row(127, -128, -128, -128, -1),
            mk_row(-128, -128, -128, 127, -1), mk_exp(127, 127, -1));
    add_vec("k2_avg_extreme", 1'b1, 16'hFFFF, mk_row(127, 127, -128, -128, 127),
            mk_row(127, 127, -128, -128, 127), mk_exp(127, -128, 127));

    // Reset state
    #12;
    check("rst_out", out_data, '0);
    check("rst_ova", VW'(out_data_available), '0);
    check("rst_done", VW'(done_pool), '0);
    @(negedge clk);
    resetn = 1'b1;

    // K=1 max pass-through, 3 rows
    start(2'b00, 1'b0, 3);
    for (int k = 0; k < 3; k++) begin
      beat(pat(k), 16'hFFFF);
      check("k1_ova", VW'(out_data_available), VW'(1));
      check("k1_out", out_data, pat(k));
    end
    check("k1_done", VW'(done_pool), VW'(1));
    beat(pat(9), 16'hFFFF);
    check("k1_extra_ignored", VW'(out_data_available), '0);
    check("k1_hold", out_data, pat(2));
    stop();
    check("k1_done_clear", VW'(done_pool), '0);

    // K=2 table
    for (int i = 0; i < nv; i++) begin
      start(2'b01, tv[i].mode, 2);
      beat(tv[i].r0, tv[i].mask);
      check({tv[i].name, "_no_early_pulse"}, VW'(out_data_available), '0);
      beat(tv[i].r1, tv[i].mask);
      check({tv[i].name, "_pulse"}, VW'(out_data_available), VW'(1));
      check(tv[i].name, out_data, tv[i].exp);
      check({tv[i].name, "_done"}, VW'(done_pool), VW'(1));
      stop();
    end

    // K=4 avg, 6 rows: full window then partial window flushed on last row
    w1_exp = fill_lanes(4, 1, 4);
    w2_exp = fill_lanes(4, 4, 0);
    start(2'b10, 1'b1, 6);
    for (int r = 0; r < 4; r++) begin
      beat(fill_lanes(16, 0, 1), 16'hFFFF);
      if (r < 3) check("k4_no_early_pulse", VW'(out_data_available), '0);
    end
    check("k4_w1_pulse", VW'(out_data_available), VW'(1));
    check("k4_w1", out_data, w1_exp);
    beat(fill_lanes(16, 8, 0), 16'hFFFF);
    check("k4_w2_wait", VW'(out_data_available), '0);
    check("k4_hold", out_data, w1_exp);
    check("k4_not_done", VW'(done_pool), '0);
    beat(fill_lanes(16, 8, 0), 16'hFFFF);
    check("k4_w2_pulse", VW'(out_data_available), VW'(1));
    check("k4_w2", out_data, w2_exp);
    check("k4_done", VW'(done_pool), VW'(1));
    stop();

    // pool_rows = 0 completes immediately
    start(2'b01, 1'b0, 0);
    check("rows0_done", VW'(done_pool), VW'(1));
    check("rows0_no_pulse", VW'(out_data_available), '0);
    stop();

    // Abort mid-window, then a clean K=1 job
    start(2'b01, 1'b0, 4);
    beat(pat(3), 16'hFFFF);
    seen = out_data_available;
    enable_pool = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = seen | out_data_available;
    end
    check("abort_no_pulse", VW'(seen), '0);
    check("abort_no_done", VW'(done_pool), '0);
    start(2'b11, 1'b0, 1);
    beat(pat(5), 16'hFFFF);
    check("reenable_pulse", VW'(out_data_available), VW'(1));
    check("reenable_out", out_data, pat(5));
    check("reenable_done", VW'(done_pool), VW'(1));
    stop();

    // Asynchronous reset mid-job
    start(2'b00, 1'b0, 4);
    beat(pat(6), 16'hFFFF);
    check("pre_reset_out", out_data, pat(6));
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_out", out_data, '0);
    check("async_rst_ova", VW'(out_data_available), '0);
    check("async_rst_done", VW'(done_pool), '0);
    enable_pool = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
